dio_mem_writer: RTL

- Sits directly downstream of the SPI file-download controller.
- Consumes that controller's word-write strobe stream (wr/a/d, already in the system clock domain) and commits each 16-bit word into the shared BK RAM through a req/ack memory port.
- Buffers the words in a small FIFO, range-checks and rebases addresses, and holds the CPU while loading.
- Reports completion, the committed word count and error flags.

---
 rtl/dio_pkg.sv | 20 ++
 rtl/dio_word_fifo.sv | 71 +++++++
 rtl/dio_mem_writer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dio_pkg.sv
// Shared types for the download-to-memory writer: FSM states, FIFO entry layout, default base.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dio_pkg;

    localparam logic [24:0] DIO_BASE   = 25'hA0000;
    localparam int          DIO_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } dio_state_t;

    typedef struct packed {
        logic [DIO_ADDR_W-1:0] addr;
        logic [15:0]           data;
    } dio_entry_t;

endpackage

// File: rtl/dio_word_fifo.sv
// Single-clock FIFO with count/full/empty; the head entry is read straight from the storage flops.
// Latency: a word pushed at edge E is visible at head_dat after E.
// Backpressure: push into a full FIFO is ignored unless a pop happens on the same edge.
module dio_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW + 1)'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // When full, the write slot equals the head slot; the head is consumed on the same edge.
    assign do_pop  = pop_vld & ~empty;
    assign do_push = push_vld & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dio_mem_writer.sv
// Commits loader word strobes into BK RAM via req/ack, with address rebasing, range check and CPU hold.
// Latency: a word pushed at edge E0 raises mem_req after E1; the request is held until mem_ack.
// Backpressure: none toward the loader; strobes into a full FIFO are dropped and flagged in ovf_err.
module dio_mem_writer
    import dio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] BASE       = DIO_BASE,
    parameter int          ADDR_W     = DIO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dio_downloading,
    input  logic              dio_wr,
    input  logic [24:0]       dio_a,
    input  logic [15:0]       dio_d,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   words,
    output logic              ovf_err,
    output logic              range_err
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } entry_t;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    dio_state_t        state_q, state_d;
    logic              wr_prev_q, dl_prev_q;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_din_q, mem_din_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              ovf_q, ovf_d;
    logic              range_q, range_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic [24:0]       off;
    logic              wr_rise, dl_rise, dl_fall, in_range;
    logic              push_vld, pop_vld, ovf_drop, range_drop;
    entry_t            push_dat, head_dat;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;

    assign wr_rise = dio_wr & ~wr_prev_q;
    assign dl_rise = dio_downloading & ~dl_prev_q;
    assign dl_fall = ~dio_downloading & dl_prev_q;

    // Window check is done on the full 25-bit offset so wrap-around below BASE is rejected too.
    assign off        = dio_a - BASE;
    assign in_range   = (dio_a >= BASE) && ((off >> (ADDR_W + 1)) == '0);
    assign push_vld   = wr_rise & in_range;
    assign range_drop = wr_rise & ~in_range;
    assign push_dat   = '{addr: off[ADDR_W:1], data: dio_d};

    assign pop_vld  = (state_q == REQ) & mem_ack;
    assign ovf_drop = push_vld & fifo_full & ~pop_vld;

    dio_word_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        done_d     = 1'b0;
        words_d    = dl_rise ? '0 : words_q;
        if (pop_vld && !(&words_d)) begin
            words_d = words_d + 1'b1;
        end
        ovf_d   = (ovf_q & ~dl_rise) | ovf_drop;
        range_d = (range_q & ~dl_rise) | range_drop;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = head_dat.addr;
                    mem_din_d  = head_dat.data;
                end else if (dl_fall) begin
                    state_d = DRAIN;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = dio_downloading ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = head_dat.addr;
                    mem_din_d  = head_dat.data;
                end else if (dio_downloading) begin
                    // A new download started before completion was reported: no done pulse.
                    state_d = IDLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_hold_d = dio_downloading | (state_d != IDLE) | (fifo_count != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_prev_q  <= 1'b0;
            dl_prev_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            done_q     <= 1'b0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
            range_q    <= 1'b0;
            cpu_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_prev_q  <= dio_wr;
            dl_prev_q  <= dio_downloading;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            done_q     <= done_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            range_q    <= range_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign done      = done_q;
    assign words     = words_q;
    assign ovf_err   = ovf_q;
    assign range_err = range_q;
    assign cpu_hold  = cpu_hold_q;

endmodule
